demux1_7_reg: RTL
=================

Name: demux1_7_reg

Overview:
Registered 1-to-7 distributor: the write-side counterpart of the 7-input 32-bit datapath selector. One 32-bit source value is steered into one of seven holding registers chosen by a 3-bit selector. Each slot tracks its own valid flag. Consumers release slots individually. The block flags overwrites of unconsumed data and out-of-range selectors. It sits between the ALU/memory result bus and the multicycle control's destination latches.

Parameters:
WIDTH, 32, data width of the input and of every holding register
NSLOTS, 7, number of destination slots (fixed at 7; selector code 3'b111 is always out of range)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous reset, active-low: sampled on the rising edge of clk, clears the block when 0
wr_en  input  1  write request for this cycle
selector  input  3  destination slot index, 0..6 valid
data_in  input  WIDTH  value to store
clear  input  7  per-slot release; bit k clears valid[k]
data_0 .. data_6  output  WIDTH each  holding-register contents, registered
valid  output  7  per-slot occupied flag
occupancy  output  3  count of set bits in valid, registered
overwrite_err  output  1  one-cycle pulse: a write hit a slot still valid
invalid_sel_err  output  1  one-cycle pulse: wr_en with selector = 7

Behaviour:
- Reset (reset == 0 at a clk edge):
  - data_0..data_6 = 0, valid = 7'b0, occupancy = 0, both error pulses = 0.
  - Reset overrides every other input in that cycle, including a write in progress.
- Write, accepted when wr_en = 1 and selector = k with k in 0..6:
  - At the next edge, data_k <= data_in and valid[k] <= 1.
  - Latency is 1 cycle; the data is visible on data_k in the following cycle.
  - Other slots are unchanged.
- Release: clear[k] = 1 sets valid[k] <= 0 at the next edge.
  - data_k holds its last value; only the flag is dropped.
  - Multiple clear bits may be set in the same cycle.
- Write and clear to the same slot in the same cycle:
  - The write wins: valid[k] = 1, data_k = data_in.
  - overwrite_err stays 0, because the old value was consumed that cycle.
- Overwrite:
  - Condition: wr_en, selector = k, valid[k] = 1 and clear[k] = 0.
  - The data is still written, valid[k] stays 1.
  - overwrite_err = 1 for exactly the next cycle.
- Invalid selector (wr_en = 1, selector = 3'b111):
  - No register or flag changes.
  - invalid_sel_err = 1 for the next cycle. overwrite_err = 0.
- wr_en = 0: selector and data_in are ignored, no errors are raised.
- Error outputs are registered pulses. They return to 0 the cycle after unless the condition repeats.
- occupancy is the registered popcount of the next-state valid vector, so it always matches valid in the same cycle. Range is 0..7 minus the unused code, so at most 7.
- Per-slot state machine, with its encoding held by valid[k]:
  - EMPTY -> FULL on a write.
  - FULL -> EMPTY on a clear without a write.
  - FULL -> FULL on a write (flags overwrite unless clear[k] is set the same cycle).
  - EMPTY with clear[k] = 1: no-op, no error.
- No combinational path from any input to any output.

Test Plan:
- Reset then write: reset = 0 for 2 cycles, then reset = 1; wr_en = 1, selector = 3, data_in = 32'hDEADBEEF for 1 cycle -> next cycle data_3 = DEADBEEF, valid = 7'b0001000, occupancy = 1, other data_k = 0, no errors.
- Fill all slots: write k*0x11111111 to slots 0..6 on consecutive cycles -> valid = 7'h7F, occupancy = 7, data_6 = 32'h66666666.
- Overwrite: slot 2 valid holding 5, write 9 to slot 2 with clear = 0 -> data_2 = 9, valid[2] = 1, overwrite_err high exactly 1 cycle. Repeat with clear[2] = 1 in the same cycle -> data_2 = 9, valid[2] = 1, no error.
- Release: valid = 7'h7F, clear = 7'b0100101 -> valid = 7'b1011010, occupancy = 4, data unchanged.
- Invalid selector: wr_en = 1, selector = 7, data_in = 32'h12345678 -> all data/valid unchanged, invalid_sel_err high 1 cycle, overwrite_err = 0.
- Reset mid-operation: valid = 7'h7F, then reset = 0 in the same cycle as a write to slot 0 -> all outputs 0 the next cycle and the write is discarded.

Source files
------------

// File: rtl/demux1_7_reg_if.sv
// demux1_7_reg_if: write-side bus and holding-register outputs of the 1-to-7 distributor
interface demux1_7_reg_if #(parameter int WIDTH = 32);
    logic             wr_en;
    logic [2:0]       selector;
    logic [WIDTH-1:0] data_in;
    logic [6:0]       clear;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic [WIDTH-1:0] data_4;
    logic [WIDTH-1:0] data_5;
    logic [WIDTH-1:0] data_6;
    logic [6:0]       valid;
    logic [2:0]       occupancy;
    logic             overwrite_err;
    logic             invalid_sel_err;
    modport master (
        output wr_en, selector, data_in, clear,
        input  data_0, data_1, data_2, data_3, data_4, data_5, data_6,
        input  valid, occupancy, overwrite_err, invalid_sel_err
    );
    modport slave (
        input  wr_en, selector, data_in, clear,
        output data_0, data_1, data_2, data_3, data_4, data_5, data_6,
        output valid, occupancy, overwrite_err, invalid_sel_err
    );
endinterface

// File: rtl/demux1_7_reg.sv
// demux1_7_reg: steers one value into one of seven registered slots with per-slot valid flags
module demux1_7_reg #(
    parameter int WIDTH  = 32,
    parameter int NSLOTS = 7
) (
    input logic clk,
    input logic reset,
    demux1_7_reg_if.slave bus
);
    logic [WIDTH-1:0]  regs [NSLOTS];
    logic [NSLOTS-1:0] valid_q;
    logic [NSLOTS-1:0] hit;
    logic [NSLOTS-1:0] valid_n;
    logic [2:0]        occ_q;
    logic [2:0]        occ_n;
    logic              ov_q;
    logic              inv_q;

    genvar k;
    for (k = 0; k < NSLOTS; k++) begin : g_hit
        assign hit[k] = bus.wr_en && (bus.selector == 3'(k));
    end

    assign valid_n = (valid_q & ~bus.clear) | hit;

    // popcount of the next-state flags so occupancy lines up with valid
    always_comb begin
        occ_n = '0;
        for (int i = 0; i < NSLOTS; i++) occ_n = occ_n + {2'b0, valid_n[i]};
    end

    // slot registers, flags and error pulses; a write beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NSLOTS; i++) regs[i] <= '0;
            valid_q <= '0;
            occ_q   <= '0;
            ov_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) regs[i] <= hit[i] ? bus.data_in : regs[i];
            valid_q <= valid_n;
            occ_q   <= occ_n;
            ov_q    <= |(hit & valid_q & ~bus.clear);
            inv_q   <= bus.wr_en && (bus.selector == 3'd7);
        end
    end

    assign bus.data_0          = regs[0];
    assign bus.data_1          = regs[1];
    assign bus.data_2          = regs[2];
    assign bus.data_3          = regs[3];
    assign bus.data_4          = regs[4];
    assign bus.data_5          = regs[5];
    assign bus.data_6          = regs[6];
    assign bus.valid           = valid_q;
    assign bus.occupancy       = occ_q;
    assign bus.overwrite_err   = ov_q;
    assign bus.invalid_sel_err = inv_q;
endmodule
